// File: rtl/spcore_ctrl.sv
// spcore_ctrl: multi-cycle fetch/decode/execute sequencer for a small 16-bit core.
// Define SPCORE_CTRL_BRANCH_EN to enable the predicated relative branch (BRP); otherwise BRP is a NOP.
module spcore_ctrl #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            halted,
  output logic            imem_req,
  output logic [PC_W-1:0] pc,
  input  logic            imem_valid,
  input  logic [15:0]     imem_data,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ready,
  input  logic            P,
  output logic [3:0]      x,
  output logic [3:0]      y,
  output logic [3:0]      z,
  output logic [3:0]      aluc,
  output logic [1:0]      s2,
  output logic [15:0]     I,
  output logic            en,
  output logic            reg_we
);

  localparam logic [PC_W-1:0] L_RESET_PC = PC_W'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_IMM, S_MEM, S_WB, S_HALT
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [15:0]     r_ir, w_ir_nxt;
  logic [15:0]     r_imm, w_imm_nxt;

  logic [3:0] w_op;
  logic       w_is_alu, w_is_ldi, w_is_ld, w_is_st, w_is_brp, w_is_halt;

  assign w_op      = r_ir[15:12];
  assign w_is_alu  = (w_op >= 4'h1) && (w_op <= 4'h7);
  assign w_is_ldi  = (w_op == 4'h8);
  assign w_is_ld   = (w_op == 4'h9);
  assign w_is_st   = (w_op == 4'hA);
  assign w_is_brp  = (w_op == 4'hB);
  assign w_is_halt = (w_op == 4'hF);

`ifdef SPCORE_CTRL_BRANCH_EN
  logic [PC_W-1:0] w_br_off;
  assign w_br_off = PC_W'($signed(r_ir[7:0]));
`else
  logic w_unused_p;
  assign w_unused_p = P;
`endif

  // NOTE: state registers reset asynchronously and update only with non-blocking assignments.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= L_RESET_PC;
      r_ir    <= 16'h0000;
      r_imm   <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_imm   <= w_imm_nxt;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_imm_nxt   = r_imm;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    en          = 1'b0;
    reg_we      = 1'b0;
    s2          = 2'b00;
    unique case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_pc_nxt    = L_RESET_PC;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          w_ir_nxt    = imem_data;
          w_pc_nxt    = r_pc + 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_is_alu || w_is_ld || w_is_st) w_state_nxt = S_EXEC;
        else if (w_is_ldi)                  w_state_nxt = S_IMM;
        else if (w_is_halt)                 w_state_nxt = S_HALT;
`ifdef SPCORE_CTRL_BRANCH_EN
        else if (w_is_brp)                  w_state_nxt = S_EXEC;
`endif
        else                                w_state_nxt = S_FETCH;
      end
      S_EXEC: begin
        en = 1'b1;
        if (w_is_alu || w_is_ldi)    w_state_nxt = S_WB;
        else if (w_is_ld || w_is_st) w_state_nxt = S_MEM;
        else begin
          w_state_nxt = S_FETCH;
`ifdef SPCORE_CTRL_BRANCH_EN
          // Target is relative to the already-incremented pc.
          if (w_is_brp && P) w_pc_nxt = r_pc + w_br_off;
`endif
        end
      end
      S_IMM: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          w_imm_nxt   = imem_data;
          w_pc_nxt    = r_pc + 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_is_st;
        if (dmem_ready) w_state_nxt = w_is_ld ? S_WB : S_FETCH;
      end
      S_WB: begin
        reg_we      = 1'b1;
        s2          = w_is_ldi ? 2'b01 : (w_is_ld ? 2'b10 : 2'b00);
        w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign pc     = r_pc;
  assign I      = r_imm;
  assign x      = r_ir[7:4];
  assign y      = r_ir[3:0];
  assign z      = r_ir[11:8];
  assign aluc   = w_is_alu ? w_op : 4'h0;
  assign busy   = (r_state != S_IDLE) && (r_state != S_HALT);
  assign halted = (r_state == S_HALT);

endmodule
